multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control FSM that sequences the shared multi-cycle datapath for the MIPS subset: R-type, addi, slti, lw, sw, beq.
- The datapath has one memory port, one ALU, an IR and ALUOut/MDR latches; this block drives every mux select and strobe, state by state.
- The block waits on a single memory-ready handshake and counts retired instructions.
- It sits between the IR opcode field and the datapath, replacing the single-cycle decoder.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-low reset
- instr_op_i  input  6  opcode from IR[31:26]; stable outside FETCH
- mem_ready_i  input  1  memory completes current MemRead/MemWrite this cycle
- PCWrite_o  output  1  unconditional PC load
- PCWriteCond_o  output  1  PC load if ALU zero
- PCSource_o  output  1  0=ALU result (PC+4), 1=ALUOut (branch target)
- IorD_o  output  1  memory address: 0=PC, 1=ALUOut
- IRWrite_o  output  1  IR load
- MemRead_o  output  1  memory read request
- MemWrite_o  output  1  memory write request
- MemtoReg_o  output  1  write-back data: 0=ALUOut, 1=MDR
- RegDst_o  output  1  dest reg: 0=rt, 1=rd
- RegWrite_o  output  1  register-file write
- ALUSrcA_o  output  1  0=PC, 1=rs
- ALUSrcB_o  output  2  00=rt, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALU_op_o  output  3  000=add, 001=sub, 010=use funct, 011=slt
- state_o  output  4  current state, debug
- illegal_o  output  1  sticky: unsupported opcode decoded
- instr_cnt_o  output  CNT_W  retired-instruction count

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, IMM_EX=8, IMM_WB=9, BR=10, ILLEGAL=11.
  - Codes 12-15 go to FETCH on the next edge.
- Outputs are Moore decodes of state. Any signal not listed for a state is 0.
- Reset:
  - While rst_i=0: state=FETCH, illegal_o=0, instr_cnt_o=0, and all strobe/select outputs are forced to 0.
  - Reset asserted mid-instruction aborts it immediately. No partial write-back is permitted after the reset edge.
  - First fetch starts on the first rising edge after rst_i rises.
- FETCH:
  - MemRead=1, ALUSrcB=01, ALU_op=add.
  - IRWrite and PCWrite = mem_ready_i.
  - Holds until mem_ready_i=1, then goes to DECODE.
- DECODE:
  - ALUSrcB=11, ALU_op=add (precomputes branch target).
  - Next state by opcode: 0x00 to R_EX; 0x23/0x2B to MEM_ADDR; 0x08/0x0A to IMM_EX; 0x04 to BR.
  - Any other opcode goes to ILLEGAL.
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, add.
  - Goes to MEM_RD if opcode 0x23, else MEM_WR.
- MEM_RD:
  - MemRead=1, IorD=1.
  - Holds until mem_ready_i, then goes to MEM_WB.
- MEM_WB:
  - RegWrite=1, MemtoReg=1, RegDst=0.
  - Goes to FETCH.
- MEM_WR:
  - MemWrite=1, IorD=1.
  - Holds until mem_ready_i, then goes to FETCH.
- R_EX:
  - ALUSrcA=1, ALUSrcB=00, ALU_op=010.
  - Goes to R_WB.
- R_WB:
  - RegWrite=1, RegDst=1.
  - Goes to FETCH.
- IMM_EX:
  - ALUSrcA=1, ALUSrcB=10.
  - ALU_op=add for 0x08, slt for 0x0A.
  - Goes to IMM_WB.
- IMM_WB:
  - RegWrite=1, RegDst=0, MemtoReg=0.
  - Goes to FETCH.
- BR:
  - ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSource=1.
  - Goes to FETCH.
- ILLEGAL:
  - All strobes 0, illegal_o=1.
  - Absorbing until reset.
- Latencies with mem_ready_i=1 every request:
  - beq 3 cycles.
  - R-type, addi, slti, sw 4 cycles.
  - lw 5 cycles.
  - Each wait cycle adds 1.
- instr_cnt_o:
  - Increments by 1 on the edge leaving MEM_WB, MEM_WR (when ready), R_WB, IMM_WB or BR.
  - Wraps modulo 2^CNT_W.
  - Never increments in ILLEGAL.
- MemRead_o and MemWrite_o are never both 1 in the same cycle.
- RegWrite_o and a memory strobe are never both 1 in the same cycle.
- mem_ready_i is ignored in states without a memory request.

Test Plan:
- Reset release, then addi (op 0x08), mem_ready_i tied 1 -> state_o sequence 0,1,8,9,0. RegWrite_o=1 only in cycle 4, ALU_op_o=000 in IMM_EX. instr_cnt_o 0 to 1.
- lw (0x23) with mem_ready_i low 2 cycles in FETCH and 3 in MEM_RD -> 10 total cycles. IRWrite_o pulses once, MemtoReg_o=1 with RegWrite_o in MEM_WB.
- beq (0x04) -> 3 cycles. PCWriteCond_o=1, PCSource_o=1, ALU_op_o=001 in BR. PCWrite_o=0 there.
- Back-to-back sw (0x2B), R-type (0x00), slti (0x0A) -> cycle counts 4,4,4. RegDst_o=1 only in R_WB, ALU_op_o=011 in slti IMM_EX. instr_cnt_o=3.
- Opcode 0x02 -> ILLEGAL after DECODE. illegal_o=1 and held for 20 cycles, no strobes, counter frozen. rst_i low clears it.
- rst_i pulsed low during MEM_RD (mid-lw) -> outputs 0 asynchronously, state_o=0, counter=0. No RegWrite_o pulse afterward until a new instruction completes.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multi-cycle MIPS-subset datapath
// (R-type, addi, slti, lw, sw, beq). Drives every mux select and strobe
// of the datapath as a Moore decode of the current state, waits on a
// single memory-ready handshake, and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             PCSource_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALU_op_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EX     = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_IMM_EX   = 4'd8;
  localparam logic [3:0] S_IMM_WB   = 4'd9;
  localparam logic [3:0] S_BR       = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       retire;

  // State register; reset returns to FETCH and aborts any instruction in flight.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic: opcode dispatch in DECODE, memory waits in FETCH/MEM_RD/MEM_WR.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:         state_nxt = S_R_EX;
          OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
          OP_ADDI, OP_SLTI: state_nxt = S_IMM_EX;
          OP_BEQ:           state_nxt = S_BR;
          default:          state_nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: state_nxt = (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_nxt = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   state_nxt = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_R_EX:     state_nxt = S_R_WB;
      S_R_WB:     state_nxt = S_FETCH;
      S_IMM_EX:   state_nxt = S_IMM_WB;
      S_IMM_WB:   state_nxt = S_FETCH;
      S_BR:       state_nxt = S_FETCH;
      S_ILLEGAL:  state_nxt = S_ILLEGAL;
      default:    state_nxt = S_FETCH;   // unused codes 12-15 recover
    endcase
  end

  // Datapath control decode; everything is forced low while reset is held,
  // so even the FETCH read request is suppressed until rst_i rises.
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 1'b0;
    IorD_o        = 1'b0;
    IRWrite_o     = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALU_op_o      = ALU_ADD;
    illegal_o     = 1'b0;
    if (rst_i) begin
      case (state)
        S_FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'b01;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        S_DECODE:   ALUSrcB_o = 2'b11;
        S_MEM_ADDR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
        end
        S_MEM_RD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite_o = 1'b1;
          MemtoReg_o = 1'b1;
        end
        S_MEM_WR: begin
          MemWrite_o = 1'b1;
          IorD_o     = 1'b1;
        end
        S_R_EX: begin
          ALUSrcA_o = 1'b1;
          ALU_op_o  = ALU_FUNCT;
        end
        S_R_WB: begin
          RegWrite_o = 1'b1;
          RegDst_o   = 1'b1;
        end
        S_IMM_EX: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'b10;
          ALU_op_o  = (instr_op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_IMM_WB:   RegWrite_o = 1'b1;
        S_BR: begin
          ALUSrcA_o     = 1'b1;
          ALU_op_o      = ALU_SUB;
          PCWriteCond_o = 1'b1;
          PCSource_o    = 1'b1;
        end
        S_ILLEGAL:  illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

  // An instruction retires on the edge that leaves its last state.
  always_comb begin
    retire = (state == S_MEM_WB) || (state == S_R_WB) ||
             (state == S_IMM_WB) || (state == S_BR)   ||
             ((state == S_MEM_WR) && mem_ready_i);
  end

  // Retired-instruction counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      instr_cnt_o <= '0;
    else if (retire) instr_cnt_o <= instr_cnt_o + CNT_W'(1);
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle table of
// {opcode, mem_ready, expected state, expected control word, expected count}
// plus hand-written reset sequences around the table runs.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  // Control word order:
  // PCWrite PCWriteCond PCSource IorD IRWrite MemRead MemWrite MemtoReg
  // RegDst RegWrite ALUSrcA ALUSrcB[1:0] ALU_op[2:0] illegal
  typedef logic [16:0] ctrl_t;

  //                                  pw  pwc psrc iord irw mrd mwr m2r rdst rw srca srcb  aluop ill
  localparam ctrl_t C_ZERO      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
  localparam ctrl_t C_FETCH_RDY = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b0};
  localparam ctrl_t C_FETCH_WT  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b0};
  localparam ctrl_t C_DECODE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,1'b0};
  localparam ctrl_t C_MEM_ADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,1'b0};
  localparam ctrl_t C_MEM_RD    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
  localparam ctrl_t C_MEM_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,1'b0};
  localparam ctrl_t C_MEM_WR    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0};
  localparam ctrl_t C_R_EX      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,1'b0};
  localparam ctrl_t C_R_WB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,1'b0};
  localparam ctrl_t C_IMM_ADD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,1'b0};
  localparam ctrl_t C_IMM_SLT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b011,1'b0};
  localparam ctrl_t C_IMM_WB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,1'b0};
  localparam ctrl_t C_BR        = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,1'b0};
  localparam ctrl_t C_ILLEGAL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1};

  typedef struct {
    logic [5:0]       op;
    logic             rdy;
    logic [3:0]       exp_state;
    ctrl_t            exp_ctrl;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [5:0]       instr_op_i;
  logic             mem_ready_i;
  logic             PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, IRWrite_o;
  logic             MemRead_o, MemWrite_o, MemtoReg_o, RegDst_o, RegWrite_o;
  logic             ALUSrcA_o;
  logic [1:0]       ALUSrcB_o;
  logic [2:0]       ALU_op_o;
  logic [3:0]       state_o;
  logic             illegal_o;
  logic [CNT_W-1:0] instr_cnt_o;
  ctrl_t            act_ctrl;

  int tests  = 0;
  int failed = 0;
  vec_t vq[$];

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_op_i   (instr_op_i),
    .mem_ready_i  (mem_ready_i),
    .PCWrite_o    (PCWrite_o),
    .PCWriteCond_o(PCWriteCond_o),
    .PCSource_o   (PCSource_o),
    .IorD_o       (IorD_o),
    .IRWrite_o    (IRWrite_o),
    .MemRead_o    (MemRead_o),
    .MemWrite_o   (MemWrite_o),
    .MemtoReg_o   (MemtoReg_o),
    .RegDst_o     (RegDst_o),
    .RegWrite_o   (RegWrite_o),
    .ALUSrcA_o    (ALUSrcA_o),
    .ALUSrcB_o    (ALUSrcB_o),
    .ALU_op_o     (ALU_op_o),
    .state_o      (state_o),
    .illegal_o    (illegal_o),
    .instr_cnt_o  (instr_cnt_o)
  );

  assign act_ctrl = {PCWrite_o, PCWriteCond_o, PCSource_o, IorD_o, IRWrite_o,
                     MemRead_o, MemWrite_o, MemtoReg_o, RegDst_o, RegWrite_o,
                     ALUSrcA_o, ALUSrcB_o, ALU_op_o, illegal_o};

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                     input ctrl_t c, input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.op = op; v.rdy = rdy; v.exp_state = st; v.exp_ctrl = c; v.exp_cnt = cnt;
    vq.push_back(v);
  endtask

  // Entered just after a falling edge; drives one vector per cycle, checks
  // mid-low-phase, and returns just after the next falling edge.
  task automatic run_all(input string tag);
    foreach (vq[i]) begin
      instr_op_i  = vq[i].op;
      mem_ready_i = vq[i].rdy;
      #1;
      check($sformatf("%s[%0d] state", tag, i), 32'(state_o), 32'(vq[i].exp_state));
      check($sformatf("%s[%0d] ctrl", tag, i), 32'(act_ctrl), 32'(vq[i].exp_ctrl));
      check($sformatf("%s[%0d] cnt", tag, i), 32'(instr_cnt_o), 32'(vq[i].exp_cnt));
      @(posedge clk_i);
      @(negedge clk_i);
    end
    vq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state"}, 32'(state_o), 32'd0);
    check({tag, " ctrl"}, 32'(act_ctrl), 32'(C_ZERO));
    check({tag, " cnt"}, 32'(instr_cnt_o), 32'd0);
  endtask

  initial begin
    rst_i       = 1'b0;
    instr_op_i  = 6'h00;
    mem_ready_i = 1'b1;

    // Reset held: FETCH state but every strobe forced low, even with ready high.
    #2;
    check_reset_outputs("reset t0");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset held");
    rst_i = 1'b1;

    // addi, ready tied high: 0,1,8,9 then count 0->1.
    add(6'h08, 1'b1, 4'd0,  C_FETCH_RDY, 0);
    add(6'h08, 1'b1, 4'd1,  C_DECODE,    0);
    add(6'h08, 1'b1, 4'd8,  C_IMM_ADD,   0);
    add(6'h08, 1'b1, 4'd9,  C_IMM_WB,    0);
    // lw: 2 wait cycles in FETCH, 3 in MEM_RD -> 10 cycles.
    add(6'h23, 1'b0, 4'd0,  C_FETCH_WT,  1);
    add(6'h23, 1'b0, 4'd0,  C_FETCH_WT,  1);
    add(6'h23, 1'b1, 4'd0,  C_FETCH_RDY, 1);
    add(6'h23, 1'b0, 4'd1,  C_DECODE,    1);
    add(6'h23, 1'b0, 4'd2,  C_MEM_ADDR,  1);
    add(6'h23, 1'b0, 4'd3,  C_MEM_RD,    1);
    add(6'h23, 1'b0, 4'd3,  C_MEM_RD,    1);
    add(6'h23, 1'b0, 4'd3,  C_MEM_RD,    1);
    add(6'h23, 1'b1, 4'd3,  C_MEM_RD,    1);
    add(6'h23, 1'b0, 4'd4,  C_MEM_WB,    1);
    // beq, ready low outside FETCH (must be ignored): 3 cycles.
    add(6'h04, 1'b1, 4'd0,  C_FETCH_RDY, 2);
    add(6'h04, 1'b0, 4'd1,  C_DECODE,    2);
    add(6'h04, 1'b0, 4'd10, C_BR,        2);
    // sw, R-type, slti back to back: 4 cycles each.
    add(6'h2B, 1'b1, 4'd0,  C_FETCH_RDY, 3);
    add(6'h2B, 1'b1, 4'd1,  C_DECODE,    3);
    add(6'h2B, 1'b1, 4'd2,  C_MEM_ADDR,  3);
    add(6'h2B, 1'b1, 4'd5,  C_MEM_WR,    3);
    add(6'h00, 1'b1, 4'd0,  C_FETCH_RDY, 4);
    add(6'h00, 1'b1, 4'd1,  C_DECODE,    4);
    add(6'h00, 1'b1, 4'd6,  C_R_EX,      4);
    add(6'h00, 1'b1, 4'd7,  C_R_WB,      4);
    add(6'h0A, 1'b1, 4'd0,  C_FETCH_RDY, 5);
    add(6'h0A, 1'b1, 4'd1,  C_DECODE,    5);
    add(6'h0A, 1'b1, 4'd8,  C_IMM_SLT,   5);
    add(6'h0A, 1'b1, 4'd9,  C_IMM_WB,    5);
    // Unsupported opcode 0x02: ILLEGAL is absorbing, counter frozen.
    add(6'h02, 1'b1, 4'd0,  C_FETCH_RDY, 6);
    add(6'h02, 1'b1, 4'd1,  C_DECODE,    6);
    for (int k = 0; k < 20; k++)
      add(6'h02, 1'(k % 2), 4'd11, C_ILLEGAL, 6);
    run_all("seq");

    // Reset clears the sticky illegal flag and the counter asynchronously.
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("illegal clr");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // lw parked in MEM_RD, then reset mid-cycle with ready high.
    add(6'h23, 1'b1, 4'd0,  C_FETCH_RDY, 0);
    add(6'h23, 1'b1, 4'd1,  C_DECODE,    0);
    add(6'h23, 1'b1, 4'd2,  C_MEM_ADDR,  0);
    add(6'h23, 1'b0, 4'd3,  C_MEM_RD,    0);
    run_all("lw pre");
    mem_ready_i = 1'b1;
    #1;
    check("lw rd ready state", 32'(state_o), 32'd3);
    check("lw rd ready ctrl", 32'(act_ctrl), 32'(C_MEM_RD));
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("mid lw async");
    @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("mid lw held");
    rst_i = 1'b1;

    // After the abort: no write-back until a fresh instruction completes.
    add(6'h23, 1'b0, 4'd0,  C_FETCH_WT,  0);
    add(6'h23, 1'b0, 4'd0,  C_FETCH_WT,  0);
    add(6'h08, 1'b1, 4'd0,  C_FETCH_RDY, 0);
    add(6'h08, 1'b1, 4'd1,  C_DECODE,    0);
    add(6'h08, 1'b1, 4'd8,  C_IMM_ADD,   0);
    add(6'h08, 1'b1, 4'd9,  C_IMM_WB,    0);
    add(6'h08, 1'b0, 4'd0,  C_FETCH_WT,  1);
    run_all("post");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
